// File: rtl/traffic_pkg.sv
// Shared phase encodings and next-way selection for the traffic_ctrl slice.
package traffic_pkg;

   localparam logic [1:0] PH_GREEN  = 2'd0;
   localparam logic [1:0] PH_YELLOW = 2'd1;
   localparam logic [1:0] PH_ALLRED = 2'd2;
   localparam logic [1:0] PH_EMERG  = 2'd3;

   localparam int unsigned MAX_WAYS = 16;

   // First requesting way after cur in cyclic order; plain round-robin when nothing requests.
   // cur is only re-selected when it is the sole requester (reached at k == n).
   function automatic logic [3:0] next_way_sel(input logic [3:0]          cur,
                                                input logic [MAX_WAYS-1:0] dem,
                                                input int unsigned         n);
      logic [3:0]  sel;
      logic        found;
      int unsigned idx;
      sel   = (cur == 4'(n - 1)) ? '0 : cur + 4'd1;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_WAYS; k++) begin
         idx = 32'(cur) + k;
         if (idx >= n) idx = idx - n;
         if (!found && (k <= n) && dem[idx[3:0]]) begin
            sel   = idx[3:0];
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/traffic_ctrl_if.sv
// Control inputs and lamp outputs of traffic_ctrl, bundled for the intersection top level.
interface traffic_ctrl_if #(parameter int unsigned N_WAYS = 4);

   localparam int unsigned AW = $clog2(N_WAYS);

   logic              tick;
   logic              emerg;
   logic [N_WAYS-1:0] demand;
   logic [N_WAYS-1:0] green;
   logic [N_WAYS-1:0] yellow;
   logic [N_WAYS-1:0] red;
   logic [AW-1:0]     active_way;
   logic [1:0]        phase;

   modport master (output tick, emerg, demand,
                   input  green, yellow, red, active_way, phase);

   modport slave  (input  tick, emerg, demand,
                   output green, yellow, red, active_way, phase);

endinterface

// File: rtl/traffic_phase_timer.sv
// Loadable down-counter timing each light phase; advances only on tick.
module traffic_phase_timer #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] tmr;

   always_ff @(posedge clk) begin
      if (rst)
         tmr <= CNT_W'(RST_VAL);
      else if (load)
         tmr <= load_val;
      else if (tick && (tmr != '0))
         tmr <= tmr - 1'b1;
   end

   assign done = tick && (tmr == '0);

endmodule

// File: rtl/traffic_ctrl.sv
// N-way traffic-light controller with emergency all-red override.
// Define TRAFFIC_DEMAND_SKIP_EN to pick the next green way from the demand flags.
module traffic_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned N_WAYS     = 4,
   parameter int unsigned GREEN_CYC  = 7,
   parameter int unsigned YELLOW_CYC = 1,
   parameter int unsigned ALLRED_CYC = 1,
   parameter int unsigned CNT_W      = 8
) (
   input  logic           clk,
   input  logic           rst,
   traffic_ctrl_if.slave  bus
);

   localparam int unsigned      AW   = $clog2(N_WAYS);
   localparam logic [CNT_W-1:0] G_LD = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] Y_LD = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] A_LD = CNT_W'(ALLRED_CYC - 1);

   logic [1:0]          state, state_nxt;
   logic [AW-1:0]       way, way_nxt, way_sel;
   logic                load, done;
   logic [CNT_W-1:0]    load_val;
   logic [MAX_WAYS-1:0] dem;
   logic [N_WAYS-1:0]   green_nxt, yellow_nxt;

`ifdef TRAFFIC_DEMAND_SKIP_EN
   assign dem = MAX_WAYS'(bus.demand);
`else
   assign dem = '0;
`endif

   assign way_sel = AW'(next_way_sel(4'(way), dem, N_WAYS));

   traffic_phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (GREEN_CYC - 1)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .tick     (bus.tick),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );

   // emerg is checked before timer expiry so it wins in every state.
   always_comb begin
      state_nxt = state;
      way_nxt   = way;
      load      = 1'b0;
      load_val  = '0;
      case (state)
         PH_GREEN: begin
            if (bus.emerg || done) begin
               state_nxt = PH_YELLOW;
               load      = 1'b1;
               load_val  = Y_LD;
            end
         end
         PH_YELLOW: begin
            if (done) begin
               state_nxt = bus.emerg ? PH_EMERG : PH_ALLRED;
               load      = 1'b1;
               load_val  = A_LD;
            end
         end
         PH_ALLRED: begin
            if (bus.emerg) begin
               state_nxt = PH_EMERG;
            end else if (done) begin
               state_nxt = PH_GREEN;
               way_nxt   = way_sel;
               load      = 1'b1;
               load_val  = G_LD;
            end
         end
         default: begin
            if (!bus.emerg && bus.tick) begin
               state_nxt = PH_ALLRED;
               load      = 1'b1;
               load_val  = A_LD;
            end
         end
      endcase
   end

   // Lamps are decoded from the next state so they register in step with it.
   always_comb begin
      green_nxt  = '0;
      yellow_nxt = '0;
      if (state_nxt == PH_GREEN)
         green_nxt = N_WAYS'(1) << way_nxt;
      else if (state_nxt == PH_YELLOW)
         yellow_nxt = N_WAYS'(1) << way_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= PH_GREEN;
         way        <= '0;
         bus.green  <= N_WAYS'(1);
         bus.yellow <= '0;
         bus.red    <= ~N_WAYS'(1);
      end else begin
         state      <= state_nxt;
         way        <= way_nxt;
         bus.green  <= green_nxt;
         bus.yellow <= yellow_nxt;
         bus.red    <= ~(green_nxt | yellow_nxt);
      end
   end

   assign bus.phase      = state;
   assign bus.active_way = way;

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

- Parametrised N-way traffic-light controller. Successor to the fixed 4-way, 32-state counter-and-decode light sequencer.
- Provides:
  - programmable green, yellow and all-red clearance durations,
  - a tick enable for slow time bases,
  - an emergency all-red override,
  - an optional demand-driven phase skip.
- Sits between the system time base and the lamp-driver outputs of the intersection top level.

## Interface
Parameters:
- N_WAYS, 4, number of approaches served round-robin (2..16)
- GREEN_CYC, 7, ticks each way holds green (≥1)
- YELLOW_CYC, 1, ticks of yellow after green (≥1)
- ALLRED_CYC, 1, ticks of all-red clearance before next green (≥1)
- CNT_W, 8, phase-timer width; every *_CYC must be < 2^CNT_W

Ports:
- clk, in, 1, single clock; all state updates on posedge clk
- rst, in, 1, synchronous, active-high reset
- tick, in, 1, timing enable; phase timers advance only in cycles with tick=1
- emerg, in, 1, emergency request; sampled every clk, not tick-qualified
- demand, in, N_WAYS, per-way vehicle-present flags (used only with TRAFFIC_DEMAND_SKIP_EN)
- green, out, N_WAYS, green lamp per way
- yellow, out, N_WAYS, yellow lamp per way
- red, out, N_WAYS, red lamp per way
- active_way, out, $clog2(N_WAYS), way currently owning right-of-way
- phase, out, 2, current state code (GREEN=0, YELLOW=1, ALLRED=2, EMERG=3)

## Operation
- **States:** GREEN, YELLOW, ALLRED, EMERG. A down-counter `tmr` is loaded on entry to each timed state.
- **Reset:**
  - state=GREEN, active_way=0, tmr=GREEN_CYC-1.
  - green=1 on way 0 only; red=1 on all other ways; yellow=0.
- **Timer:** on a tick with tmr≠0, tmr decrements. On a tick with tmr=0, the state transitions.
  - GREEN→YELLOW (load YELLOW_CYC-1)
  - YELLOW→ALLRED (load ALLRED_CYC-1)
  - ALLRED→GREEN of next way (load GREEN_CYC-1)
- **Next way:** active_way+1, wrapping N_WAYS-1→0. active_way updates on the ALLRED→GREEN transition.
- **Lamp decode:** from state and active_way.
  - GREEN: green[active_way]=1.
  - YELLOW: yellow[active_way]=1.
  - ALLRED / EMERG: red on all ways.
  - Non-active ways are always red.
  - Invariant: each way has exactly one of red/yellow/green set, and at most one way is non-red.
- **Emergency:**
  - emerg=1 in GREEN: go to YELLOW next cycle with a full YELLOW_CYC.
  - emerg=1 in YELLOW: finish the current yellow.
  - emerg=1 in ALLRED: go to EMERG next cycle.
  - YELLOW with emerg=1 at expiry goes to EMERG (not ALLRED).
  - EMERG holds all-red while emerg=1.
  - On emerg=0: EMERG→ALLRED with a full ALLRED_CYC, then green for the next way.
- **Simultaneous events:**
  - emerg has priority over tick-expiry in every state.
  - rst has priority over everything.
  - rst mid-phase returns to the reset state on the next edge with no partial lamp states.

## Timing
- All outputs are registered and change one clk after the causing state update. No combinational path from inputs to outputs.
- With tick held at 1, one way's cycle lasts GREEN_CYC+YELLOW_CYC+ALLRED_CYC clks. The full rotation is N_WAYS times that.
- With tick=0, all state is frozen (emerg entry excepted).
- Emergency latency, from emerg rising to all-red:
  - In GREEN: 1 + YELLOW_CYC ticks.
  - In ALLRED: 1 clk.

## Configuration
- **TRAFFIC_DEMAND_SKIP_EN defined:**
  - At ALLRED expiry, next way = first way after active_way (cyclic order) with demand=1.
  - If no demand bit is set, next way = active_way+1.
  - The current way may be selected again only if it is the sole requester.
- **Undefined:** demand is ignored (unconnected internally) and strict round-robin applies.

## Structure
- **traffic_pkg:** phase encoding constants/enum (PH_GREEN, PH_YELLOW, PH_ALLRED, PH_EMERG) and a next-way-select function.
- **Sub-module traffic_phase_timer:** loadable CNT_W-bit down-counter with tick enable and `done` flag (tmr==0 & tick).
- **Top:** FSM, way pointer, lamp decode.

## Test plan
- Reset, N_WAYS=4, 7/1/1, tick=1 → way0 green cycles 0–6, yellow cycle 7, all-red cycle 8, way1 green at cycle 9; way0 green again at cycle 36.
- tick asserted every 3rd clk → way0 green lasts 21 clks; outputs frozen between ticks.
- emerg pulsed high at clk 3 for 10 clks → yellow[0] at clk 4, all-red from clk 5, held through emerg; one ALLRED tick after release, then green[1].
- rst asserted during way2 yellow → next edge green[0]=1, others red, phase=0.
- TRAFFIC_DEMAND_SKIP_EN, demand=4'b1000 during way0 green → after way0 all-red, green[3]; demand=0 → way1.
- Every cycle: assert lamp one-hot-per-way and ≤1 non-red way (concurrent checker).
